microcode_sequencer: RTL and testbench
======================================

# microcode_sequencer

Control sequencer for the non-pipelined microprogrammed RV32I datapath. Steps the datapath through fetch, decode, execute, memory and write-back micro-states per instruction, and handles the memory request/ready handshake. Drives every datapath write-enable and mux select, and counts retired instructions. It sits beside `Datapath` inside the processor wrapper, takes the opcode and branch flag from it, and returns the control word.

## Interface
- `OPC_W`, default 7: opcode field width.
- `CNT_W`, default 32: retired-instruction counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching.
- `opcode` in OPC_W: `IR[6:0]`, valid from DECODE onward.
- `branch_taken` in 1: datapath compare result, combinational, valid in BRANCH.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req`, `mem_we` out 1: memory request and write qualifier.
- `ir_we`, `pc_we`, `rf_we` out 1: IR, PC (latches OLDPC) and regfile write enables.
- `pc_sel` out 2: 00 PC+4, 01 OLDPC+imm, 10 (rs1+imm)&~1.
- `wb_sel` out 2: 00 ALU, 01 memory data, 10 OLDPC+4, 11 immediate.
- `alu_src_b` out 1: 0 rs2, 1 imm.
- `alu_op` out 2: 00 add, 01 compare, 10 funct-decoded.
- `instr_done` out 1: one-cycle pulse on an instruction's final cycle.
- `instr_count` out CNT_W: retired instructions, wraps modulo 2^CNT_W.
- `halted` out 1: sticky after ECALL/EBREAK (or trap).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JALR, LUI, HALT, TRAP (trap only with macro).
- IDLE → FETCH when `start`=1.
- FETCH: `mem_req`=1, `mem_we`=0. Holds until `mem_ready`. On the ready cycle: `ir_we`=1, `pc_we`=1, `pc_sel`=00, then → DECODE.
- DECODE: no enables. Dispatch on `opcode`:
  - 0110011 → EXEC (`alu_src_b`=0, `alu_op`=10).
  - 0010011 → EXEC (`alu_src_b`=1, `alu_op`=10).
  - 0000011 → ADDR.
  - 0100011 → ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JUMP.
  - 1100111 → JALR.
  - 0110111 → LUI.
  - 1110011 → HALT.
  - Anything else → illegal (see Configuration).
- EXEC → WB_ALU (`rf_we`=1, `wb_sel`=00, ALU selects held).
- ADDR (`alu_src_b`=1, `alu_op`=00) → MEM_RD for loads, MEM_WR for stores.
- MEM_RD: `mem_req`=1. Waits for `mem_ready`, then → WB_MEM (`rf_we`=1, `wb_sel`=01).
- MEM_WR: `mem_req`=1, `mem_we`=1. Waits for `mem_ready`; completes the instruction on the ready cycle.
- BRANCH: `alu_op`=01, `pc_sel`=01, `pc_we`=`branch_taken` (the only Mealy output). Last cycle.
- JUMP: `rf_we`=1, `wb_sel`=10, `pc_we`=1, `pc_sel`=01. Last cycle.
- JALR: same as JUMP but `pc_sel`=10.
- LUI: `rf_we`=1, `wb_sel`=11. Last cycle.
- Last cycle of any instruction: `instr_done`=1, `instr_count`+1, next state FETCH.
- HALT: `halted`=1, counts as retired on entry cycle, absorbing until `rst`. `start` ignored.

## Timing
- Reset: state IDLE, all control outputs 0, `instr_count`=0, `halted`=0, `instr_done`=0.
- State register updates on `clk`. Outputs are decoded from current state, except `pc_we` in BRANCH and the ready-qualified enables in FETCH, MEM_RD and MEM_WR.
- Cycles with `mem_ready` tied high:
  - R/I-ALU 4, load 5, store 4.
  - branch 3, JAL/JALR 3, LUI 3.
  - Each `mem_ready`-low cycle adds one.
- Handshake:
  - `mem_req` stays asserted and `mem_we` is stable while waiting.
  - `mem_ready` while `mem_req`=0 is ignored.
  - Request and ready in the same cycle completes it.
- `rst` mid-instruction, including during a memory wait: state returns to IDLE next edge, `mem_req` drops, no partial `rf_we`/`pc_we`.
- `instr_count` at all ones + retire → 0.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - Illegal opcode: DECODE → TRAP.
  - TRAP asserts `halted`=1, is absorbing, and does not pulse `instr_done` or increment the count.
- `ILLEGAL_TRAP_EN` undefined:
  - Illegal opcode is a NOP: DECODE → FETCH with `instr_done`=1 and count+1.
  - PC is already advanced by FETCH.

## Test plan
- Reset, `start`=1, `mem_ready`=1, R-type 0x00B50533 → states FETCH, DECODE, EXEC, WB_ALU. `rf_we`=1 only in cycle 4, `wb_sel`=00, `instr_count`=1.
- Load 0x0002A303 with `mem_ready` low 3 cycles in MEM_RD → 8 cycles total. `mem_req` held steady, `rf_we` with `wb_sel`=01 one cycle after ready.
- Branch 0x00B50463: once with `branch_taken`=1 (`pc_we`=1, `pc_sel`=01), once with 0 (`pc_we`=0). Both 3 cycles, `instr_done` pulses.
- JAL then ECALL 0x00000073 → JUMP asserts `rf_we`, `wb_sel`=10, `pc_we`. After ECALL, `halted`=1, count=2, `start` pulse ignored.
- Opcode 0x0000007F:
  - With `ILLEGAL_TRAP_EN`: TRAP, `halted`=1, count unchanged.
  - Without: next FETCH, count+1.
- `rst` asserted during a MEM_WR wait → IDLE next cycle, all outputs 0. Preload `instr_count`=0xFFFFFFFF via force, retire one → 0.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: control word, opcode/branch feedback and memory handshake
// between the microcode sequencer (master) and the RV32I datapath/memory (slave).
interface microcode_sequencer_if #(
    parameter int OPC_W = 7,
    parameter int CNT_W = 32
);
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic             rf_we;
    logic [1:0]       pc_sel;
    logic [1:0]       wb_sel;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic             halted;

    modport master (
        input  start, opcode, branch_taken, mem_ready,
        output mem_req, mem_we, ir_we, pc_we, rf_we, pc_sel, wb_sel,
               alu_src_b, alu_op, instr_done, instr_count, halted
    );

    modport slave (
        output start, opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, ir_we, pc_we, rf_we, pc_sel, wb_sel,
               alu_src_b, alu_op, instr_done, instr_count, halted
    );
endinterface

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: multi-cycle RV32I control FSM with memory handshake and retire counter.
// ILLEGAL_TRAP_EN: illegal opcodes enter an absorbing TRAP instead of retiring as a NOP.
module microcode_sequencer #(
    parameter int OPC_W = 7,
    parameter int CNT_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    microcode_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM,
        BRANCH, JUMP, JALR, LUI, HALT
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OPC_W-1:0] opc;
    logic [6:0]       op;
    logic             fetch_ok, done;

    assign opc = bus.opcode;
    assign op  = 7'(opc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = bus.start ? FETCH : IDLE;
            FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:
                case (op)
                    OP_R, OP_IMM:      state_d = EXEC;
                    OP_LOAD, OP_STORE: state_d = ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JUMP;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_SYS:            state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            EXEC:   state_d = WB_ALU;
            ADDR:   state_d = op == OP_STORE ? MEM_WR : MEM_RD;
            MEM_RD: state_d = bus.mem_ready ? WB_MEM : MEM_RD;
            MEM_WR: state_d = bus.mem_ready ? FETCH : MEM_WR;
            WB_ALU, WB_MEM, BRANCH, JUMP, JALR, LUI: state_d = FETCH;
            default: state_d = state_q;
        endcase
    end

    // DECODE retires on its own cycle for ECALL/EBREAK and for an illegal NOP.
    always_comb begin
        done = !rst && (state_q inside {WB_ALU, WB_MEM, BRANCH, JUMP, JALR, LUI}
            || (state_q == MEM_WR && bus.mem_ready)
            || (state_q == DECODE && (state_d == HALT || state_d == FETCH)));
        count_d = count_q + CNT_W'(done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign fetch_ok        = state_q == FETCH && bus.mem_ready;
    assign bus.mem_req     = state_q inside {FETCH, MEM_RD, MEM_WR};
    assign bus.mem_we      = state_q == MEM_WR;
    assign bus.ir_we       = !rst && fetch_ok;
    assign bus.pc_we       = !rst && (fetch_ok || (state_q == BRANCH && bus.branch_taken)
                             || state_q inside {JUMP, JALR});
    assign bus.rf_we       = !rst && state_q inside {WB_ALU, WB_MEM, JUMP, JALR, LUI};
    assign bus.pc_sel      = state_q inside {BRANCH, JUMP} ? 2'b01 : state_q == JALR ? 2'b10 : 2'b00;
    assign bus.wb_sel      = state_q == WB_MEM ? 2'b01 : state_q inside {JUMP, JALR} ? 2'b10 :
                             state_q == LUI ? 2'b11 : 2'b00;
    assign bus.alu_src_b   = state_q == ADDR || (state_q inside {EXEC, WB_ALU} && op == OP_IMM);
    assign bus.alu_op      = state_q == BRANCH ? 2'b01 : state_q inside {EXEC, WB_ALU} ? 2'b10 : 2'b00;
    assign bus.instr_done  = done;
    assign bus.instr_count = count_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.halted      = state_q inside {HALT, TRAP};
`else
    assign bus.halted      = state_q == HALT;
`endif
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: table-driven, hand-written and randomized checks of the sequencer.
module tb_microcode_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    microcode_sequencer_if #(.OPC_W(7), .CNT_W(32)) bus();
    microcode_sequencer #(.OPC_W(7), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic rdy, tk, req, we, rf, pc, done;} cyc_t;
    typedef struct {logic [6:0] op; logic tk; int cyc; int rf_n; logic [1:0] wb; int pc_n; logic [1:0] pcs;} vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mcount;
    cyc_t        q[$];
    vec_t        tab[$];
    logic [6:0]  ops[$] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic jr();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(logic rdy, logic tk, logic req, logic we, logic rf, logic pc, logic dn);
        return '{rdy, tk, req, we, rf, pc, dn};
    endfunction

    function automatic vec_t mv(logic [6:0] op, logic tk, int c, int r, logic [1:0] wb, int p, logic [1:0] ps);
        return '{op, tk, c, r, wb, p, ps};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.rf_we, bus.pc_sel, bus.wb_sel,
                bus.alu_src_b, bus.alu_op, bus.instr_done, bus.halted};
    endfunction

    // Per-cycle expectation list for one instruction, built from the instruction's micro-step recipe.
    task automatic plan(input logic [6:0] op, input int wf, input int wd, input logic tk);
        q.delete();
        repeat (wf) q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 0, 0, 1, 0));
        q.push_back(mk(jr(), 0, 0, 0, 0, 0,
            !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37})));
        case (op)
            7'h33, 7'h13: begin
                q.push_back(mk(jr(), 0, 0, 0, 0, 0, 0));
                q.push_back(mk(jr(), 0, 0, 0, 1, 0, 1));
            end
            7'h03: begin
                q.push_back(mk(jr(), 0, 0, 0, 0, 0, 0));
                repeat (wd) q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
                q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
                q.push_back(mk(jr(), 0, 0, 0, 1, 0, 1));
            end
            7'h23: begin
                q.push_back(mk(jr(), 0, 0, 0, 0, 0, 0));
                repeat (wd) q.push_back(mk(0, 0, 1, 1, 0, 0, 0));
                q.push_back(mk(1, 0, 1, 1, 0, 0, 1));
            end
            7'h63:        q.push_back(mk(jr(), tk, 0, 0, 0, tk, 1));
            7'h6F, 7'h67: q.push_back(mk(jr(), 0, 0, 0, 1, 1, 1));
            7'h37:        q.push_back(mk(jr(), 0, 0, 0, 1, 0, 1));
            default: ;
        endcase
        bus.opcode = op;
    endtask

    task automatic run_q(input string name);
        foreach (q[i]) begin
            bus.mem_ready    = q[i].rdy;
            bus.branch_taken = q[i].tk;
            @(negedge clk);
            chk(name, {bus.mem_req, bus.mem_we, bus.rf_we, bus.pc_we, bus.instr_done},
                {q[i].req, q[i].we, q[i].rf, q[i].pc, q[i].done});
            tick();
        end
        mcount++;
        chk({name, "_cnt"}, bus.instr_count, mcount);
    endtask

    task automatic run_tab(input vec_t v);
        int cyc = 0, rf_n = 0, pc_n = 0;
        logic [1:0] wb = '0, pcs = '0;
        logic dn = 1'b0;
        bus.opcode = v.op;
        bus.branch_taken = v.tk;
        bus.mem_ready = 1'b1;
        while (!dn && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.rf_we) begin rf_n++; wb = bus.wb_sel; end
            if (bus.pc_we) begin pc_n++; pcs = bus.pc_sel; end
            dn = bus.instr_done;
            tick();
        end
        mcount++;
        chk($sformatf("tab_%02h_%0d", v.op, v.tk),
            {cyc[7:0], rf_n[3:0], wb, pc_n[3:0], pcs, bus.instr_count},
            {v.cyc[7:0], v.rf_n[3:0], v.wb, v.pc_n[3:0], v.pcs, mcount});
    endtask

    task automatic alu_case(input logic [6:0] op, input logic [2:0] alu);
        bus.opcode = op;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk($sformatf("alu_exec_%02h", op), {bus.alu_src_b, bus.alu_op, bus.rf_we}, {alu, 1'b0});
        tick();
        @(negedge clk);
        chk($sformatf("alu_wb_%02h", op), {bus.alu_src_b, bus.alu_op, bus.rf_we, bus.wb_sel, bus.instr_done},
            {alu, 1'b1, 2'b00, 1'b1});
        tick();
        mcount++;
        chk("alu_cnt", bus.instr_count, mcount);
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        mcount = '0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b0;
`ifndef ILLEGAL_TRAP_EN
        ops.push_back(7'h7F);
`endif
        tab.push_back(mv(7'h33, 0, 4, 1, 2'b00, 1, 2'b00));
        tab.push_back(mv(7'h13, 0, 4, 1, 2'b00, 1, 2'b00));
        tab.push_back(mv(7'h03, 0, 5, 1, 2'b01, 1, 2'b00));
        tab.push_back(mv(7'h23, 0, 4, 0, 2'b00, 1, 2'b00));
        tab.push_back(mv(7'h63, 1, 3, 0, 2'b00, 2, 2'b01));
        tab.push_back(mv(7'h63, 0, 3, 0, 2'b00, 1, 2'b00));
        tab.push_back(mv(7'h6F, 0, 3, 1, 2'b10, 2, 2'b01));
        tab.push_back(mv(7'h67, 0, 3, 1, 2'b10, 2, 2'b10));
        tab.push_back(mv(7'h37, 0, 3, 1, 2'b11, 1, 2'b00));
`ifndef ILLEGAL_TRAP_EN
        tab.push_back(mv(7'h7F, 0, 2, 0, 2'b00, 1, 2'b00));
`endif

        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        chk("reset_cnt", bus.instr_count, 0);
        mcount = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        alu_case(7'h33, 3'b010);
        alu_case(7'h13, 3'b110);
        foreach (tab[i]) run_tab(tab[i]);

        plan(7'h03, 0, 3, 1'b0);
        run_q("load_wait");

        repeat (150) begin
            plan(ops[$urandom_range(0, ops.size() - 1)], $urandom_range(0, 2), $urandom_range(0, 3), jr());
            run_q("rand");
        end

        // Reset in the middle of a store's memory wait.
        bus.opcode = 7'h23;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("mw_wait1", {bus.mem_req, bus.mem_we, bus.instr_done}, 3'b110);
        tick();
        @(negedge clk);
        chk("mw_wait2", {bus.mem_req, bus.mem_we, bus.instr_done}, 3'b110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mw_outs", outs(), 0);
        chk("rst_mw_cnt", bus.instr_count, 0);

        mcount = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        plan(7'h6F, 0, 0, 1'b0);
        run_q("jal");
        bus.opcode = 7'h73;
        bus.mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ecall_done", bus.instr_done, 1);
        tick();
        @(negedge clk);
        chk("ecall_halt", {bus.halted, bus.instr_count}, {1'b1, 32'd2});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        @(negedge clk);
        chk("halt_sticky", {bus.halted, bus.mem_req, bus.instr_count}, {1'b1, 1'b0, 32'd2});

`ifdef ILLEGAL_TRAP_EN
        restart();
        bus.opcode = 7'h7F;
        bus.mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("trap_nodone", bus.instr_done, 0);
        tick();
        @(negedge clk);
        chk("trap_halt", {bus.halted, bus.instr_count}, {1'b1, 32'd0});
        tick();
        tick();
        @(negedge clk);
        chk("trap_sticky", {bus.halted, bus.mem_req, bus.instr_done}, 3'b100);
`endif

        restart();
        force dut.count_q = '1;
        #1;
        release dut.count_q;
        mcount = '1;
        plan(7'h37, 0, 0, 1'b0);
        run_q("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
